// File: rtl/upg_loader_if.sv
// Boot-loader byte stream, response handshake and shared programming write port.
// master = loader controller, slave = UART / memory side.
interface upg_loader_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_ready_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i,
    output tx_valid_o, tx_data_o, upg_wen_o, upg_adr_o, upg_dat_o,
           upg_done_o, upg_err_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i,
    input  tx_valid_o, tx_data_o, upg_wen_o, upg_adr_o, upg_dat_o,
           upg_done_o, upg_err_o
  );
endinterface

// File: rtl/upg_loader_ctrl.sv
// UART boot-loader sequencer: frames CMD/CNT/DATA/CSUM segments, assembles
// little-endian words onto the programming port and answers ACK/NAK per segment.
module upg_loader_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned MAX_WORDS      = 16384
) (
  input logic          upg_clk_i,
  input logic          upg_rst_n_i,
  upg_loader_if.master bus
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_ERR, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             seg_sel_q;
  logic [13:0]      word_idx_q;
  logic [7:0]       cnt_lo_q;
  logic [15:0]      word_cnt_q;
  logic [1:0]       byte_idx_q;
  logic [23:0]      asm_q;
  logic [7:0]       chk_q;
  logic [TMO_W-1:0] tmo_q;

  logic        in_frame, tmo_hit, last_byte, last_word, queue_ack, queue_nak;
  logic [15:0] cnt_rx;

  assign cnt_rx = {bus.rx_data_i, cnt_lo_q};

  always_comb begin
    state_d   = state_q;
    in_frame  = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                (state_q == S_DATA)   || (state_q == S_CSUM);
    tmo_hit   = in_frame && !bus.rx_valid_i &&
                (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    last_byte = (byte_idx_q == 2'd3);
    last_word = ((16'(word_idx_q) + 16'd1) == word_cnt_q);
    queue_ack = ((state_q == S_CSUM) && bus.rx_valid_i && (bus.rx_data_i == chk_q)) ||
                ((state_q == S_DONE) && !bus.upg_done_o);
    queue_nak = (state_q == S_ERR);
    unique case (state_q)
      S_IDLE: if (bus.rx_valid_i) begin
        if ((bus.rx_data_i == 8'h01) || (bus.rx_data_i == 8'h02)) state_d = S_CNT_LO;
        else if (bus.rx_data_i == 8'hFF)                          state_d = S_DONE;
        else                                                      state_d = S_ERR;
      end
      S_CNT_LO: if (bus.rx_valid_i) state_d = S_CNT_HI;
                else if (tmo_hit)   state_d = S_ERR;
      S_CNT_HI: if (bus.rx_valid_i) begin
        if ({1'b0, cnt_rx} > 17'(MAX_WORDS)) state_d = S_ERR;
        else if (cnt_rx == 16'd0)            state_d = S_CSUM;
        else                                 state_d = S_DATA;
      end else if (tmo_hit) state_d = S_ERR;
      S_DATA: if (bus.rx_valid_i) begin
        if (last_byte && last_word) state_d = S_CSUM;
      end else if (tmo_hit) state_d = S_ERR;
      S_CSUM: if (bus.rx_valid_i) state_d = (bus.rx_data_i == chk_q) ? S_IDLE : S_ERR;
              else if (tmo_hit)   state_d = S_ERR;
      S_ERR:   state_d = S_IDLE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      seg_sel_q      <= 1'b0;
      word_idx_q     <= '0;
      cnt_lo_q       <= '0;
      word_cnt_q     <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
      chk_q          <= '0;
      tmo_q          <= '0;
      bus.tx_valid_o <= 1'b0;
      bus.tx_data_o  <= '0;
      bus.upg_wen_o  <= 1'b0;
      bus.upg_adr_o  <= '0;
      bus.upg_dat_o  <= '0;
      bus.upg_done_o <= 1'b0;
      bus.upg_err_o  <= 1'b0;
    end else begin
      bus.upg_wen_o <= 1'b0;
      if (!in_frame || bus.rx_valid_i) tmo_q <= '0;
      else                             tmo_q <= tmo_q + TMO_W'(1);

      if (bus.rx_valid_i) begin
        unique case (state_q)
          S_IDLE: begin
            seg_sel_q  <= (bus.rx_data_i == 8'h02);
            chk_q      <= bus.rx_data_i;
            word_idx_q <= '0;
            byte_idx_q <= '0;
          end
          S_CNT_LO: begin
            cnt_lo_q <= bus.rx_data_i;
            chk_q    <= chk_q ^ bus.rx_data_i;
          end
          S_CNT_HI: begin
            word_cnt_q <= cnt_rx;
            chk_q      <= chk_q ^ bus.rx_data_i;
            byte_idx_q <= '0;
          end
          S_DATA: begin
            // Bytes enter at the top so the first one ends up in bits 7:0.
            chk_q      <= chk_q ^ bus.rx_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (last_byte) begin
              bus.upg_wen_o <= 1'b1;
              bus.upg_dat_o <= {bus.rx_data_i, asm_q};
              bus.upg_adr_o <= {seg_sel_q, word_idx_q};
              word_idx_q    <= word_idx_q + 14'd1;
            end else begin
              asm_q <= {bus.rx_data_i, asm_q[23:8]};
            end
          end
          default: ;
        endcase
      end

      if (state_q == S_ERR)                       bus.upg_err_o  <= 1'b1;
      if ((state_q == S_DONE) && !bus.upg_done_o) bus.upg_done_o <= 1'b1;

      // A fresh response overwrites one the host has not yet taken.
      if (queue_ack || queue_nak) begin
        bus.tx_valid_o <= 1'b1;
        bus.tx_data_o  <= queue_nak ? NAK : ACK;
      end else if (bus.tx_valid_o && bus.tx_ready_i) begin
        bus.tx_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_upg_loader_ctrl.sv
// Directed bench for upg_loader_ctrl: segment framing, word writes, ACK/NAK,
// timeout, END handling and asynchronous reset.
module tb_upg_loader_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  upg_loader_if bus ();

  upg_loader_ctrl #(.TIMEOUT_CYCLES(100), .MAX_WORDS(16384)) dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  logic [46:0] wen_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  stim[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.upg_wen_o) wen_q.push_back({bus.upg_adr_o, bus.upg_dat_o});
      if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_data_o);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_stim(input bit add_cs, input logic [7:0] cs_flip);
    logic [7:0] cs;
    cs = 8'h00;
    foreach (stim[i]) begin
      cs = cs ^ stim[i];
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = stim[i];
      @(negedge clk);
    end
    if (add_cs) begin
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = cs ^ cs_flip;
      @(negedge clk);
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_valid_i = 1'b0;
    idle(2);
    rst_n = 1'b1;
    wen_q.delete();
    tx_q.delete();
  endtask

  task automatic test_reset();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b1;
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({bus.tx_valid_o, bus.tx_data_o, bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o,
         bus.upg_done_o, bus.upg_err_o} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs: tx_v=%b tx_d=%h wen=%b adr=%h dat=%h done=%b err=%b, required all 0",
               bus.tx_valid_o, bus.tx_data_o, bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o,
               bus.upg_done_o, bus.upg_err_o);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_rom_segment();
    do_reset();
    stim = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(1'b1, 8'h00);
    idle(6);
    checks++;
    if (wen_q.size() !== 2) begin errors++; $display("FAIL rom_wen_count: got %0d, required 2", wen_q.size()); end
    if (wen_q.size() > 0) begin
      checks++;
      if (wen_q[0] !== {15'h0000, 32'h12345678}) begin errors++; $display("FAIL rom_word0: got %h, required %h", wen_q[0], {15'h0000, 32'h12345678}); end
    end
    if (wen_q.size() > 1) begin
      checks++;
      if (wen_q[1] !== {15'h0001, 32'hDEADBEEF}) begin errors++; $display("FAIL rom_word1: got %h, required %h", wen_q[1], {15'h0001, 32'hDEADBEEF}); end
    end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL rom_ack: got %0d bytes first %h, required 1 byte 06", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++;
    if (bus.upg_err_o !== 1'b0) begin errors++; $display("FAIL rom_err: got %b, required 0", bus.upg_err_o); end
    checks++;
    if (bus.upg_adr_o !== 15'h0001 || bus.upg_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rom_hold: adr %h dat %h, required 0001 DEADBEEF", bus.upg_adr_o, bus.upg_dat_o); end
  endtask

  task automatic test_data_segment();
    do_reset();
    stim = '{8'h02, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(1'b1, 8'h00);
    idle(6);
    checks++;
    if (wen_q.size() !== 1 || wen_q[0] !== {15'h4000, 32'hDDCCBBAA}) begin errors++; $display("FAIL data_word: got %0d writes first %h, required 1 write %h", wen_q.size(), (wen_q.size() > 0) ? wen_q[0] : 47'hx, {15'h4000, 32'hDDCCBBAA}); end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL data_ack: got %0d bytes first %h, required 1 byte 06", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    stim = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(1'b1, 8'h01);
    idle(6);
    checks++;
    if (wen_q.size() !== 2) begin errors++; $display("FAIL badcs_wen_count: got %0d, required 2", wen_q.size()); end
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin errors++; $display("FAIL badcs_nak: got %0d bytes first %h, required 1 byte 15", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++;
    if (bus.upg_err_o !== 1'b1) begin errors++; $display("FAIL badcs_err: got %b, required 1", bus.upg_err_o); end
    stim = '{8'h02, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(1'b1, 8'h00);
    idle(6);
    checks++;
    if (wen_q.size() !== 3 || wen_q[2] !== {15'h4000, 32'hDDCCBBAA}) begin errors++; $display("FAIL badcs_recover_word: got %0d writes, required 3 ending %h", wen_q.size(), {15'h4000, 32'hDDCCBBAA}); end
    checks++;
    if (tx_q.size() !== 2 || tx_q[1] !== 8'h06) begin errors++; $display("FAIL badcs_recover_ack: got %0d bytes, required 2 ending 06", tx_q.size()); end
    checks++;
    if (bus.upg_err_o !== 1'b1) begin errors++; $display("FAIL badcs_err_sticky: got %b, required 1", bus.upg_err_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    stim = '{8'h01, 8'h05, 8'h00, 8'h11};
    send_stim(1'b0, 8'h00);
    idle(90);
    checks++;
    if (tx_q.size() !== 0 || bus.upg_err_o !== 1'b0) begin errors++; $display("FAIL tmo_early: got %0d tx bytes err %b, required 0 and 0", tx_q.size(), bus.upg_err_o); end
    idle(30);
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15) begin errors++; $display("FAIL tmo_nak: got %0d bytes first %h, required 1 byte 15", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
    checks++;
    if (bus.upg_err_o !== 1'b1 || wen_q.size() !== 0) begin errors++; $display("FAIL tmo_err_wen: err %b writes %0d, required 1 and 0", bus.upg_err_o, wen_q.size()); end
    stim = '{8'h02, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(1'b1, 8'h00);
    idle(6);
    checks++;
    if (tx_q.size() !== 2 || tx_q[1] !== 8'h06 || wen_q.size() !== 1) begin errors++; $display("FAIL tmo_next_cmd: tx %0d writes %0d, required 2 (ending 06) and 1", tx_q.size(), wen_q.size()); end
  endtask

  task automatic test_bad_cmd_and_size();
    do_reset();
    stim = '{8'h07};
    send_stim(1'b0, 8'h00);
    idle(4);
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h15 || bus.upg_err_o !== 1'b1) begin errors++; $display("FAIL badcmd: tx %0d err %b, required 1 NAK and err 1", tx_q.size(), bus.upg_err_o); end
    do_reset();
    stim = '{8'h01, 8'h01, 8'h41};
    send_stim(1'b0, 8'h00);
    idle(4);
    stim = '{8'h01, 8'h01, 8'h40};
    send_stim(1'b0, 8'h00);
    idle(4);
    checks++;
    if (tx_q.size() !== 2 || tx_q[0] !== 8'h15 || tx_q[1] !== 8'h15) begin errors++; $display("FAIL oversize_nak: got %0d bytes, required 2 NAKs", tx_q.size()); end
    checks++;
    if (wen_q.size() !== 0 || bus.upg_err_o !== 1'b1) begin errors++; $display("FAIL oversize_wen: writes %0d err %b, required 0 and 1", wen_q.size(), bus.upg_err_o); end
    stim = '{8'h01, 8'h00, 8'h00};
    send_stim(1'b1, 8'h00);
    idle(4);
    checks++;
    if (tx_q.size() !== 3 || tx_q[2] !== 8'h06 || wen_q.size() !== 0) begin errors++; $display("FAIL zero_count: tx %0d writes %0d, required 3 ending ACK and 0", tx_q.size(), wen_q.size()); end
  endtask

  task automatic test_tx_overwrite();
    do_reset();
    bus.tx_ready_i = 1'b0;
    stim = '{8'h07};
    send_stim(1'b0, 8'h00);
    idle(3);
    checks++;
    if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h15) begin errors++; $display("FAIL txhold_nak: valid %b data %h, required 1 15", bus.tx_valid_o, bus.tx_data_o); end
    stim = '{8'h01, 8'h00, 8'h00};
    send_stim(1'b1, 8'h00);
    idle(3);
    checks++;
    if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h06) begin errors++; $display("FAIL txhold_overwrite: valid %b data %h, required 1 06", bus.tx_valid_o, bus.tx_data_o); end
    bus.tx_ready_i = 1'b1;
    idle(3);
    checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h06 || bus.tx_valid_o !== 1'b0) begin errors++; $display("FAIL txhold_drain: got %0d bytes valid %b, required 1 byte 06 valid 0", tx_q.size(), bus.tx_valid_o); end
  endtask

  task automatic test_done();
    do_reset();
    stim = '{8'hFF};
    send_stim(1'b0, 8'h00);
    idle(4);
    checks++;
    if (bus.upg_done_o !== 1'b1 || tx_q.size() !== 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL done_ack: done %b tx %0d, required 1 and one ACK", bus.upg_done_o, tx_q.size()); end
    stim = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stim(1'b1, 8'h00);
    idle(6);
    checks++;
    if (wen_q.size() !== 0 || tx_q.size() !== 1 || bus.upg_done_o !== 1'b1 || bus.upg_err_o !== 1'b0) begin errors++; $display("FAIL done_ignore: writes %0d tx %0d done %b err %b, required 0 1 1 0", wen_q.size(), tx_q.size(), bus.upg_done_o, bus.upg_err_o); end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    stim = '{8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stim(1'b0, 8'h00);
    checks++;
    if (wen_q.size() !== 1 || wen_q[0] !== {15'h0000, 32'h44332211}) begin errors++; $display("FAIL midrst_first_word: got %0d writes, required 1 of %h", wen_q.size(), {15'h0000, 32'h44332211}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_valid_o, bus.tx_data_o, bus.upg_wen_o, bus.upg_adr_o, bus.upg_dat_o,
         bus.upg_done_o, bus.upg_err_o} !== 59'd0) begin
      errors++;
      $display("FAIL midrst_async: adr=%h dat=%h wen=%b tx_v=%b, required all 0",
               bus.upg_adr_o, bus.upg_dat_o, bus.upg_wen_o, bus.tx_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stim = '{8'h77, 8'h88};
    send_stim(1'b0, 8'h00);
    idle(6);
    checks++;
    if (wen_q.size() !== 1) begin errors++; $display("FAIL midrst_no_write: got %0d writes, required 1", wen_q.size()); end
  endtask

  initial begin
    test_reset();
    test_rom_segment();
    test_data_segment();
    test_bad_checksum();
    test_timeout();
    test_bad_cmd_and_size();
    test_tx_overwrite();
    test_done();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
